// File: rtl/hazard_pkg.sv
// +--------------------------------------------------------------------------+
// | hazard_pkg : shared types and the register-match helper for the hazard  |
// | sequencer.                                    Revision: 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_LOADUSE = 2'd1,
    CAUSE_BRANCH  = 2'd2,
    CAUSE_MULDIV  = 2'd3
  } hz_cause_e;

  // $0 is hard-wired, so a producer targeting it can never create a hazard.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_wait_timer.sv
// +--------------------------------------------------------------------------+
// | muldiv_wait_timer : down-counter timing the multiply/divide freeze.     |
// |                                               Revision: 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_wait_timer #(
  parameter int MULDIV_LAT = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  logic [W-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (load) begin
      md_cnt_d = W'(MULDIV_LAT - 1);
    end else if (dec && (md_cnt_q != '0)) begin
      md_cnt_d = md_cnt_q - W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign done = (md_cnt_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush/freeze sequencer beside ID.          |
// | Optional perf counters enabled by HAZARD_PERF_EN.  Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       In_ID_Rs,
  input  logic [4:0]       In_ID_Rt,
  input  logic             In_ID_UsesRt,
  input  logic             In_ID_Branch,
  input  logic             In_ID_MulDiv,
  input  logic             In_PCSrc,
  input  logic             In_Jump,
  input  logic             In_EX_MemRead,
  input  logic             In_EX_RegWrite,
  input  logic [4:0]       In_EX_WriteReg,
  input  logic             In_MEM_MemRead,
  input  logic [4:0]       In_MEM_WriteReg,
  output logic             Out_PCWrite,
  output logic             Out_IFIDWrite,
  output logic             Out_IFIDFlush,
  output logic             Out_IDEXBubble,
  output logic             Out_PipeHold,
  output logic             Out_EXMEMBubble,
  output logic [1:0]       Out_StallCause,
  output logic [CNT_W-1:0] Out_StallCycles,
  output logic [CNT_W-1:0] Out_FlushCount
);

  hz_state_e state_q, state_d;
  hz_cause_e cause;
  logic      load_use, branch_haz, md_start, md_done;

  assign load_use   = In_EX_MemRead && reg_match(In_EX_WriteReg, In_ID_Rs, In_ID_Rt, In_ID_UsesRt);
  assign branch_haz = In_ID_Branch &&
                      ((In_EX_RegWrite && reg_match(In_EX_WriteReg, In_ID_Rs, In_ID_Rt, In_ID_UsesRt)) ||
                       (In_MEM_MemRead && reg_match(In_MEM_WriteReg, In_ID_Rs, In_ID_Rt, In_ID_UsesRt)));

  always_comb begin
    Out_PCWrite     = 1'b1;
    Out_IFIDWrite   = 1'b1;
    Out_IFIDFlush   = 1'b0;
    Out_IDEXBubble  = 1'b0;
    Out_PipeHold    = 1'b0;
    Out_EXMEMBubble = 1'b0;
    cause           = CAUSE_NONE;
    md_start        = 1'b0;
    state_d         = state_q;
    if (Rst_n) begin
      if (state_q == MD_WAIT) begin
        // Redirects are ignored here; the branch in ID is re-evaluated after the freeze.
        Out_PCWrite     = 1'b0;
        Out_IFIDWrite   = 1'b0;
        Out_PipeHold    = 1'b1;
        Out_EXMEMBubble = 1'b1;
        cause           = CAUSE_MULDIV;
        if (md_done) begin
          state_d = RUN;
        end
      end else if (load_use || branch_haz) begin
        Out_PCWrite    = 1'b0;
        Out_IFIDWrite  = 1'b0;
        Out_IDEXBubble = 1'b1;
        cause          = load_use ? CAUSE_LOADUSE : CAUSE_BRANCH;
      end else begin
        Out_IFIDFlush = In_PCSrc || In_Jump;
        if (In_ID_MulDiv) begin
          md_start = 1'b1;
          state_d  = MD_WAIT;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  muldiv_wait_timer #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_md_timer (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (md_start),
    .dec   (state_q == MD_WAIT),
    .done  (md_done)
  );

  assign Out_StallCause = cause;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((cause != CAUSE_NONE) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (Out_IFIDFlush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign Out_StallCycles = stall_cycles_q;
  assign Out_FlushCount  = flush_count_q;
`else
  assign Out_StallCycles = '0;
  assign Out_FlushCount  = '0;
`endif

endmodule

`default_nettype wire
